// File: rtl/tx_contention_ctrl.sv
// Multi-queue transmit contention controller: round-robin grant of backoff-complete
// queues, per-queue retry and contention-window tracking, result/timeout handling.
module tx_contention_ctrl #(
    parameter int RETRY_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tsf_pulse_1M,
    input  logic [3:0]             high_tx_allowed,
    input  logic [3:0]             queue_pending,
    input  logic [3:0]             cw_exp_min,
    input  logic [3:0]             cw_exp_max,
    input  logic [RETRY_WIDTH-1:0] retry_limit,
    input  logic [15:0]            result_timeout_top,
    input  logic                   tx_result_strobe,
    input  logic                   tx_result_ok,
    output logic [3:0]             cw_exp,
    output logic                   tx_start,
    output logic [1:0]             tx_queue_idx,
    output logic                   tx_busy,
    output logic                   success_strobe,
    output logic                   drop_strobe,
    output logic [1:0]             report_queue_idx,
    output logic [RETRY_WIDTH-1:0] retry_count
);

    // state       | meaning
    // IDLE        | waiting for an eligible queue; grants round-robin from rr_ptr
    // WAIT_RESULT | frame in flight; waiting for result strobe or timeout
    // UPDATE      | one cycle: apply retry/cw bookkeeping for the granted queue
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_RESULT = 2'd1,
        UPDATE      = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             rr_ptr_q, rr_ptr_d;
    logic [1:0]             tx_queue_idx_q, tx_queue_idx_d;
    logic [1:0]             report_queue_idx_q, report_queue_idx_d;
    logic [15:0]            tmo_cnt_q, tmo_cnt_d;
    logic [RETRY_WIDTH-1:0] retry_q [4];
    logic [RETRY_WIDTH-1:0] retry_d [4];
    logic [3:0]             cw_q [4];
    logic [3:0]             cw_d [4];
    logic                   tx_start_q, tx_start_d;
    logic                   success_q, success_d;
    logic                   drop_q, drop_d;
    logic                   tx_busy_q, tx_busy_d;
    logic [3:0]             cw_exp_q, cw_exp_d;
    logic [RETRY_WIDTH-1:0] retry_count_q, retry_count_d;

    logic [3:0] cmin;
    logic [3:0] eligible;
    logic [2:0] grant_sel;
    logic [2:0] pend_sel;
    logic [3:0] cw_cur;
    logic [4:0] cw_inc;
    logic       outcome_ok;
    logic       outcome_now;

    // {found, idx}: first set bit of mask searching upward (mod 4) from ptr
    function automatic logic [2:0] pick_rr(input logic [3:0] mask, input logic [1:0] ptr);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (mask[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    // A queue's stored exponent may sit outside the current window (reset value
    // 0, or config changed since), so every use goes through this clamp.
    function automatic logic [3:0] clamp_cw(input logic [3:0] cw, input logic [3:0] lo,
                                            input logic [3:0] hi);
        logic [3:0] r;
        if (cw < lo)      r = lo;
        else if (cw > hi) r = hi;
        else              r = cw;
        return r;
    endfunction

    assign cmin      = (cw_exp_min < cw_exp_max) ? cw_exp_min : cw_exp_max;
    assign eligible  = high_tx_allowed & queue_pending;
    assign grant_sel = pick_rr(eligible, rr_ptr_q);
    assign pend_sel  = pick_rr(queue_pending, rr_ptr_q);
    assign cw_cur    = clamp_cw(cw_q[tx_queue_idx_q], cmin, cw_exp_max);
    assign cw_inc    = {1'b0, cw_cur} + 5'd1;

    always_comb begin
        state_d            = state_q;
        rr_ptr_d           = rr_ptr_q;
        tx_queue_idx_d     = tx_queue_idx_q;
        report_queue_idx_d = report_queue_idx_q;
        tmo_cnt_d          = tmo_cnt_q;
        retry_d            = retry_q;
        cw_d               = cw_q;
        tx_start_d         = 1'b0;
        success_d          = 1'b0;
        drop_d             = 1'b0;
        cw_exp_d           = cw_cur;
        outcome_ok         = 1'b0;
        outcome_now        = 1'b0;

        case (state_q)
            IDLE: begin
                cw_exp_d = pend_sel[2] ? clamp_cw(cw_q[pend_sel[1:0]], cmin, cw_exp_max) : cmin;
                if (grant_sel[2]) begin
                    tx_queue_idx_d = grant_sel[1:0];
                    rr_ptr_d       = grant_sel[1:0] + 2'd1;
                    tx_start_d     = 1'b1;
                    tmo_cnt_d      = 16'd0;
                    state_d        = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                if (tx_result_strobe) begin
                    outcome_ok  = tx_result_ok;
                    outcome_now = 1'b1;
                end else if (tmo_cnt_q > result_timeout_top) begin
                    outcome_ok  = 1'b0;
                    outcome_now = 1'b1;
                end else if (tsf_pulse_1M && (tmo_cnt_q != 16'hFFFF)) begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
                // Outcome strobes are decided here so they are visible during UPDATE
                if (outcome_now) begin
                    success_d          = outcome_ok;
                    drop_d             = !outcome_ok && (retry_q[tx_queue_idx_q] >= retry_limit);
                    report_queue_idx_d = tx_queue_idx_q;
                    state_d            = UPDATE;
                end
            end
            UPDATE: begin
                if (success_q || drop_q) begin
                    retry_d[tx_queue_idx_q] = '0;
                    cw_d[tx_queue_idx_q]    = cmin;
                end else begin
                    retry_d[tx_queue_idx_q] = retry_q[tx_queue_idx_q] + 1'b1;
                    cw_d[tx_queue_idx_q]    = (cw_inc > {1'b0, cw_exp_max}) ? cw_exp_max : cw_inc[3:0];
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_busy_d     = (state_d != IDLE);
        retry_count_d = retry_d[tx_queue_idx_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            rr_ptr_q           <= 2'd0;
            tx_queue_idx_q     <= 2'd0;
            report_queue_idx_q <= 2'd0;
            tmo_cnt_q          <= 16'd0;
            for (int q = 0; q < 4; q++) begin
                retry_q[q] <= '0;
                cw_q[q]    <= 4'd0;
            end
            tx_start_q         <= 1'b0;
            success_q          <= 1'b0;
            drop_q             <= 1'b0;
            tx_busy_q          <= 1'b0;
            cw_exp_q           <= 4'd0;
            retry_count_q      <= '0;
        end else begin
            state_q            <= state_d;
            rr_ptr_q           <= rr_ptr_d;
            tx_queue_idx_q     <= tx_queue_idx_d;
            report_queue_idx_q <= report_queue_idx_d;
            tmo_cnt_q          <= tmo_cnt_d;
            for (int q = 0; q < 4; q++) begin
                retry_q[q] <= retry_d[q];
                cw_q[q]    <= cw_d[q];
            end
            tx_start_q         <= tx_start_d;
            success_q          <= success_d;
            drop_q             <= drop_d;
            tx_busy_q          <= tx_busy_d;
            cw_exp_q           <= cw_exp_d;
            retry_count_q      <= retry_count_d;
        end
    end

    assign cw_exp           = cw_exp_q;
    assign tx_start         = tx_start_q;
    assign tx_queue_idx     = tx_queue_idx_q;
    assign tx_busy          = tx_busy_q;
    assign success_strobe   = success_q;
    assign drop_strobe      = drop_q;
    assign report_queue_idx = report_queue_idx_q;
    assign retry_count      = retry_count_q;

endmodule
